// File: rtl/pipe_stage_latch.sv
// Valid/ready pipeline stage register with flush and NOP bubble on empty.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_latch #(
  parameter int              DATA_W = 32,
  parameter int              IR_W   = 32,
  parameter int              FLAG_W = 2,
  parameter logic [IR_W-1:0] NOP    = {IR_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_p,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_p,
  output logic [IR_W-1:0]   out_ir,
  output logic [FLAG_W-1:0] out_flags,
  output logic [1:0]        occupancy
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

  state_t state, state_nxt;

  logic              in_fire, out_fire;
  logic              load_head;
  logic [DATA_W-1:0] head_data_p0;
  logic [IR_W-1:0]   head_ir_p0;
  logic [FLAG_W-1:0] head_flags_p0;

`ifdef PIPE_STAGE_SKID_EN
  logic              load_skid, shift_skid;
  logic [DATA_W-1:0] skid_data_p1;
  logic [IR_W-1:0]   skid_ir_p1;
  logic [FLAG_W-1:0] skid_flags_p1;

  // in_ready decodes only the state register, so out_ready never reaches it
  assign in_ready = !reset && (state != TWO);
`else
  assign in_ready = !reset && (!out_valid || out_ready);
`endif

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_head  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid  = 1'b0;
    shift_skid = 1'b0;
`endif
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (in_fire && out_fire) begin
            load_head = 1'b1;
          end else if (in_fire) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
`else
          if (in_fire) begin
            load_head = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          if (out_fire) begin
            state_nxt  = ONE;
            shift_skid = 1'b1;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // stage p0: head register, the entry presented downstream
  always_ff @(posedge clock) begin
    if (load_head) begin
      head_data_p0  <= in_p;
      head_ir_p0    <= in_ir;
      head_flags_p0 <= in_flags;
`ifdef PIPE_STAGE_SKID_EN
    end else if (shift_skid) begin
      head_data_p0  <= skid_data_p1;
      head_ir_p0    <= skid_ir_p1;
      head_flags_p0 <= skid_flags_p1;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // stage p1: skid register, parks the entry accepted while the head stalls
  always_ff @(posedge clock) begin
    if (load_skid) begin
      skid_data_p1  <= in_p;
      skid_ir_p1    <= in_ir;
      skid_flags_p1 <= in_flags;
    end
  end
`endif

  assign out_p     = out_valid ? head_data_p0  : {DATA_W{1'b0}};
  assign out_ir    = out_valid ? head_ir_p0    : NOP;
  assign out_flags = out_valid ? head_flags_p0 : {FLAG_W{1'b0}};

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed and random traffic against pipe_stage_latch, checked by a FIFO scoreboard.
module tb_pipe_stage_latch;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] NOP_V = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] ir;
    logic [1:0]  fl;
  } ent_t;

  logic        clock, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_p, in_ir, out_p, out_ir;
  logic [1:0]  in_flags, out_flags, occupancy;

  ent_t sb[$];
  int   mocc    = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  pipe_stage_latch #(.DATA_W(32), .IR_W(32), .FLAG_W(2), .NOP(NOP_V)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_ir(in_ir), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_ir(out_ir), .out_flags(out_flags),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the scoreboard, then advance the model.
  task automatic step(input logic iv, input logic [31:0] p, input logic ordy,
                      input logic fl, input logic rs);
    ent_t e;
    logic m_rdy, m_in, m_out;
    e.p  = p;
    e.ir = p ^ 32'hA5A5_0000;
    e.fl = p[1:0] ^ 2'b10;
    in_valid = iv; in_p = e.p; in_ir = e.ir; in_flags = e.fl;
    out_ready = ordy; flush = fl; reset = rs;
    #3;
    m_rdy = !rs && (SKID ? (mocc != 2) : (mocc == 0 || ordy));
    chk("in_ready",  64'(in_ready),  64'(m_rdy));
    chk("out_valid", 64'(out_valid), 64'(mocc != 0));
    chk("occupancy", 64'(occupancy), 64'(mocc));
    if (mocc != 0) begin
      chk("out_p",     64'(out_p),     64'(sb[0].p));
      chk("out_ir",    64'(out_ir),    64'(sb[0].ir));
      chk("out_flags", 64'(out_flags), 64'(sb[0].fl));
    end else begin
      chk("out_p_empty",     64'(out_p),     64'(0));
      chk("out_ir_empty",    64'(out_ir),    64'(NOP_V));
      chk("out_flags_empty", 64'(out_flags), 64'(0));
    end
    m_in  = iv && m_rdy;
    m_out = (mocc != 0) && ordy;
    @(posedge clock);
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (m_out) void'(sb.pop_front());
      if (m_in) sb.push_back(e);
    end
    mocc = sb.size();
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_p = 32'h99; in_ir = 32'h0; in_flags = 2'b0;
    @(posedge clock);
    #1;
    // reset held with upstream offering data
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // streaming 1..8
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // backpressure: 0xA, 0xB, 0xC offered while downstream stalls
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, SKID ? 32'hC : 32'hB, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    // full skid: in_ready must ignore out_ready
    out_ready = 1'b1; #1;
    chk("skid_ready_reg_hi", 64'(in_ready), 64'(0));
    out_ready = 1'b0; #1;
    chk("skid_ready_reg_lo", 64'(in_ready), 64'(0));
    @(posedge clock); #1;
`else
    // full single register: in_ready follows out_ready within the cycle
    out_ready = 1'b0; #1;
    chk("comb_ready_lo", 64'(in_ready), 64'(0));
    out_ready = 1'b1; #1;
    chk("comb_ready_hi", 64'(in_ready), 64'(1));
    out_ready = 1'b0;
    @(posedge clock); #1;
    step(1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
`endif
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // flush a full stage while 0x55 is offered
    step(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h32, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // simultaneous in/out at occupancy 1
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // reset during backpressure discards held entries
    step(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h43, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised pipeline-stage register that replaces the fixed-width, enable-only stage latches between processor stages. It carries a payload word, an instruction word and a flag vector from stage N to stage N+1 with a valid/ready handshake, synchronous flush and automatic NOP bubble insertion. An optional two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `DATA_W`, 32, payload width (ALU result / address).
- `IR_W`, 32, instruction word width.
- `FLAG_W`, 2, sideband flag width (e.g. data_ready, exception).
- `NOP`, {IR_W{1'b0}}, instruction value presented when the stage holds no valid entry.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous squash of all held entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage can accept an entry this cycle.
- `in_p` in DATA_W: upstream payload.
- `in_ir` in IR_W: upstream instruction.
- `in_flags` in FLAG_W: upstream flags.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: downstream accepts the head entry.
- `out_p` out DATA_W: head payload.
- `out_ir` out IR_W: head instruction, `NOP` when empty.
- `out_flags` out FLAG_W: head flags.
- `occupancy` out 2: number of held entries, 0..2 (0..1 without skid).

## Operation
- Input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- Storage: main register (head) plus, with skid enabled, one skid register. Entries leave in arrival order.
- Empty head: `out_valid`=0, `out_ir`=`NOP`, `out_p`=0, `out_flags`=0.
- While `out_valid && !out_ready`, `out_p/out_ir/out_flags` are held bit-stable.
- Priority per cycle: `reset` > `flush` > handshake.
- `flush`: occupancy→0 at the next edge; an input offered in the flush cycle is dropped even if `in_ready`=1; outputs show the empty values the following cycle.
- Simultaneous in/out transfer: occupancy unchanged; new entry follows the departing one.
- Skid mode states: EMPTY (0), ONE (head valid), TWO (head+skid valid).
  - EMPTY: input → ONE.
  - ONE: input only → TWO; output only → EMPTY; both → ONE (new head).
  - TWO: output → ONE (skid moves to head); input is not accepted in TWO.
- `occupancy` reflects the registered state, never the current-cycle handshake.

## Timing
- Latency: entry accepted at edge k is on `out_*` with `out_valid`=1 after edge k (cycle k+1).
- Reset: at the edge with `reset`=1, occupancy→0, all outputs take empty values; `in_ready`=0 while `reset` is high, 1 the cycle after.
- Skid mode: `in_ready` = registered (state != TWO); no combinational path from `out_ready` to `in_ready`. Sustained throughput 1 entry/cycle with `out_ready` held high.
- Non-skid mode: `in_ready` = `!out_valid || out_ready` (combinational). Throughput 1 entry/cycle.
- Reset or flush mid-backpressure discards held entries; no entry is ever duplicated.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid buffer, registered `in_ready`, occupancy 0..2.
- Not defined: single register, combinational `in_ready`, skid register and TWO state absent, `occupancy[1]` tied 0.

## Test plan
- Reset: hold `reset` 2 cycles with `in_valid`=1 → `out_valid`=0, `out_ir`=`NOP`, `occupancy`=0, `in_ready`=0; release → `in_ready`=1 next cycle.
- Streaming: `in_p`=1..8 on consecutive cycles, `out_ready`=1 → `out_p`=1..8 on cycles 1..8 later, no gaps, `occupancy`=1 throughout.
- Backpressure (skid): send 0xA, 0xB, 0xC with `out_ready`=0 → 0xA, 0xB held, `occupancy`=2, `in_ready`=0, 0xC stalls upstream; raise `out_ready` → outputs 0xA, 0xB, 0xC in order.
- Flush: `occupancy`=2, assert `flush` with `in_valid`=1, `in_p`=0x55 → next cycle `occupancy`=0, `out_ir`=`NOP`, 0x55 never appears.
- Simultaneous: `occupancy`=1 holding 0x10, `in_p`=0x20 with `out_ready`=1 → 0x10 transfers out, `out_p`=0x20 next cycle, `occupancy`=1.
- Non-skid build: `out_ready`=0 with full stage → `in_ready`=0 same cycle; toggling `out_ready`=1 → `in_ready`=1 combinationally.
